// File: rtl/inst_buffer.sv
// Instruction buffer between I-cache fetch and issue: truncates a fetch block
// after its first predicted-taken slot, compacts survivors into a circular
// queue with per-entry PC, and presents the oldest entries to issue.
module inst_buffer #(
    parameter int unsigned FETCH_WIDTH = 4,
    parameter int unsigned ISSUE_WIDTH = 2,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned DATA_WIDTH  = 64
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              flush_i,
    input  logic                              write_valid_i,
    output logic                              write_ready_o,
    input  logic [FETCH_WIDTH-1:0]            write_mask_i,
    input  logic [FETCH_WIDTH-1:0]            write_taken_i,
    input  logic [31:0]                       write_pc_i,
    input  logic [FETCH_WIDTH*DATA_WIDTH-1:0] write_data_i,
    output logic [ISSUE_WIDTH-1:0]            read_valid_o,
    output logic [ISSUE_WIDTH*DATA_WIDTH-1:0] read_data_o,
    output logic [ISSUE_WIDTH*32-1:0]         read_pc_o,
    input  logic                              read_ready_i,
    input  logic [$clog2(ISSUE_WIDTH+1)-1:0]  read_num_i,
    output logic [$clog2(DEPTH+1)-1:0]        count_o
);

    localparam int unsigned FW_IDX = $clog2(FETCH_WIDTH);
    localparam int unsigned L      = FW_IDX + 2;
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = $clog2(DEPTH+1);

    logic [DATA_WIDTH-1:0]  mem_data [DEPTH];
    logic [31:0]            mem_pc   [DEPTH];

    logic [PTR_W-1:0]       head;
    logic [PTR_W-1:0]       tail;
    logic [CNT_W-1:0]       count;

    logic [FETCH_WIDTH-1:0] eff_mask;
    logic                   taken_seen;
    logic [CNT_W-1:0]       blk_cnt;
    logic [PTR_W-1:0]       wr_idx [FETCH_WIDTH];
    logic [31:0]            wr_pc  [FETCH_WIDTH];
    logic [PTR_W-1:0]       rd_idx [ISSUE_WIDTH];

    logic                   push_en;
    logic [CNT_W-1:0]       push_cnt;
    logic [CNT_W-1:0]       pop_cnt;
    logic [CNT_W-1:0]       num_ext;
    logic [CNT_W-1:0]       count_nxt;

    // Low PC bits select the slot inside the block and are replaced per slot.
    logic unused_pc_bits;
    assign unused_pc_bits = ^write_pc_i[L-1:0];

    assign count_o = count;

    // Truncate after first taken slot and compute compacted write positions.
    always_comb begin
        eff_mask   = write_mask_i;
        taken_seen = 1'b0;
        blk_cnt    = '0;
        wr_idx     = '{default: '0};
        wr_pc      = '{default: '0};
        for (int j = 0; j < FETCH_WIDTH; j++) begin
            if (taken_seen) begin
                eff_mask[j] = 1'b0;
            end
            if (write_mask_i[j] && write_taken_i[j]) begin
                taken_seen = 1'b1;
            end
            wr_idx[j] = tail + blk_cnt[PTR_W-1:0];
            wr_pc[j]  = {write_pc_i[31:L], FW_IDX'(j), 2'b00};
            blk_cnt   = blk_cnt + CNT_W'(eff_mask[j]);
        end
    end

    // Push/pop amounts and next occupancy; flush suppresses both.
    always_comb begin
        push_en  = write_valid_i && write_ready_o && !flush_i;
        push_cnt = push_en ? blk_cnt : '0;
        num_ext  = CNT_W'(read_num_i);
        pop_cnt  = '0;
        if (read_ready_i && !flush_i) begin
            pop_cnt = (num_ext > count) ? count : num_ext;
        end
        count_nxt = count - pop_cnt + push_cnt;
    end

    // Pointer, occupancy and ready registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            write_ready_o <= 1'b1;
        end else if (flush_i) begin
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            write_ready_o <= 1'b1;
        end else begin
            head          <= head + pop_cnt[PTR_W-1:0];
            tail          <= tail + push_cnt[PTR_W-1:0];
            count         <= count_nxt;
            write_ready_o <= (count_nxt <= CNT_W'(DEPTH - FETCH_WIDTH));
        end
    end

    // Entry storage; survivors land at consecutive slots from tail.
    always_ff @(posedge clk) begin
        for (int j = 0; j < FETCH_WIDTH; j++) begin
            if (push_en && eff_mask[j]) begin
                mem_data[wr_idx[j]] <= write_data_i[j*DATA_WIDTH +: DATA_WIDTH];
                mem_pc[wr_idx[j]]   <= wr_pc[j];
            end
        end
    end

    // Read ports show the oldest entries; port 0 is the head.
    always_comb begin
        rd_idx       = '{default: '0};
        read_valid_o = '0;
        read_data_o  = '0;
        read_pc_o    = '0;
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            rd_idx[i]                               = head + PTR_W'(i);
            read_valid_o[i]                         = (count > CNT_W'(i));
            read_data_o[i*DATA_WIDTH +: DATA_WIDTH] = mem_data[rd_idx[i]];
            read_pc_o[i*32 +: 32]                   = mem_pc[rd_idx[i]];
        end
    end

endmodule
